ahb_bus_arbiter: RTL and testbench
==================================

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
- REQ-001 Parameter NUM_MST, default 4: number of masters sharing the AHB bus; legal range 2..16.
- REQ-002 Parameter DEF_MST, default 0: default (parked) master index when no master requests.
- REQ-003 clk  input  1  bus clock; all logic on the rising edge.
- REQ-004 ahb_hreset_n  input  1  asynchronous, active-low reset.
- REQ-005 mst_hbusreq  input  NUM_MST  per-master bus request.
- REQ-006 mst_hlock  input  NUM_MST  per-master locked-access request.
- REQ-007 ahb_htrans  input  2  transfer type of the current bus owner (IDLE 0, BUSY 1, NONSEQ 2, SEQ 3).
- REQ-008 ahb_hburst  input  3  burst type of the current bus owner.
- REQ-009 ahb_hready  input  1  transfer-complete from the slave side.
- REQ-010 ahb_hresp  input  2  response (OKAY 0, ERROR 1, RETRY 2, SPLIT 3).
- REQ-011 arb_hgrant  output  NUM_MST  one-hot grant.
- REQ-012 arb_hmaster  output  $clog2(NUM_MST)  index of the master owning the address phase.
- REQ-013 arb_hmastlock  output  1  current address phase is a locked sequence.

Function
- REQ-014 The block SHALL run an FSM with states IDLE (parked on DEF_MST), BUSY (burst in progress) and LOCKED.
- REQ-015 arb_hgrant SHALL always be exactly one-hot and registered.
- REQ-016 Re-arbitration SHALL occur only in a cycle with ahb_hready=1 and a re-arbitration point.
- REQ-017 A re-arbitration point SHALL be any of: ahb_htrans=IDLE; a NONSEQ of SINGLE or INCR; the last beat of a fixed-length burst; ahb_hresp RETRY or SPLIT.
- REQ-018 A 5-bit beat counter SHALL load 4/8/16 on NONSEQ of INCR4/WRAP4, INCR8/WRAP8 and INCR16/WRAP16 with ahb_hready=1.
- REQ-019 The beat counter SHALL decrement on each SEQ with ahb_hready=1; BUSY SHALL NOT decrement it.
- REQ-020 Burst end SHALL be detected when the counter reaches 1 on an accepted beat.
- REQ-021 Selection SHALL be round-robin: search starts at (last granted index + 1) mod NUM_MST; the lowest index reached first wins.
- REQ-022 With no request at a re-arbitration point, the grant SHALL go to DEF_MST and the FSM to IDLE.
- REQ-023 Grant-to-ownership latency: arb_hmaster SHALL take the granted index on the first rising edge with ahb_hready=1 after arb_hgrant changes.
- REQ-024 While ahb_hready=0, arb_hgrant and arb_hmaster SHALL hold.
- REQ-025 If the granted master has mst_hlock=1 at a re-arbitration point, it SHALL keep the grant and the FSM SHALL enter LOCKED.
- REQ-026 LOCKED SHALL exit only after mst_hlock falls and the next transfer completes.
- REQ-027 arb_hmastlock SHALL follow mst_hlock of the owner, registered with arb_hmaster.
- REQ-028 An ERROR response SHALL NOT force re-arbitration; the burst continues to count.
- REQ-029 If the requester releases mst_hbusreq mid fixed burst, the grant SHALL be held until burst end.

Reset
- REQ-030 On ahb_hreset_n=0 (asynchronous): arb_hgrant=one-hot(DEF_MST), arb_hmaster=DEF_MST, arb_hmastlock=0, beat counter=0, FSM=IDLE, round-robin pointer=DEF_MST.
- REQ-031 Reset asserted mid-burst SHALL abort immediately; the first arbitration after deassertion SHALL use the reset pointer.

Configuration
- REQ-032 With AHB_ARB_FIXED_PRIO_EN defined, selection SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be removed.
- REQ-033 Without AHB_ARB_FIXED_PRIO_EN, selection SHALL be round-robin per REQ-021.

Structure
- REQ-034 Shared package ahb_pkg SHALL hold the htrans, hburst and hresp enums and the arbiter state enum.
- REQ-035 Selection logic SHALL be a sub-module ahb_arb_rr_pick (request vector, pointer -> one-hot winner).

Verification
- REQ-036 Reset: release with no requests -> arb_hgrant=4'b0001, arb_hmaster=0, arb_hmastlock=0.
- REQ-037 Round-robin: masters 1 and 2 request continuously with SINGLE transfers -> grants alternate 1,2,1,2; with AHB_ARB_FIXED_PRIO_EN -> always 1.
- REQ-038 Burst hold: master 3 issues INCR8 while master 0 requests -> grant stays on 3 for 8 accepted beats, including 2 BUSY cycles and hready wait states, then moves to 0.
- REQ-039 Lock: master 2 asserts mst_hlock over 3 SINGLE transfers while master 1 requests -> arb_hmastlock=1 throughout, grant stays on 2; 1 is granted after lock release plus one transfer.
- REQ-040 SPLIT: hresp=SPLIT on beat 2 of master 1's INCR4 -> re-arbitration in that cycle, grant moves to the next requester.
- REQ-041 Async reset asserted during beat 5 of INCR16 -> outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state for the bus arbiter slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  // Beat count loaded on the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [4:0] burst_beats(input hburst_e b);
    case (b)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Request picker: first requester found searching upward from (ptr + 1) mod NUM_MST.
module ahb_arb_rr_pick #(
  parameter int unsigned NUM_MST = 4,
  parameter int unsigned PW      = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_MST-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  always_comb begin
    int unsigned pos;
    logic [PW-1:0] p;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    p     = '0;
    for (int unsigned i = 1; i <= NUM_MST; i++) begin
      pos = (32'(ptr) + i) % NUM_MST;
      p   = PW'(pos);
      if (!valid && req[p]) begin
        valid  = 1'b1;
        idx    = p;
        gnt[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: registered one-hot grant, burst- and lock-aware re-arbitration.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest index) instead of round-robin.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MST = 4,
  parameter int unsigned DEF_MST = 0
) (
  input  logic                       clk,
  input  logic                       ahb_hreset_n,
  input  logic [NUM_MST-1:0]         mst_hbusreq,
  input  logic [NUM_MST-1:0]         mst_hlock,
  input  logic [1:0]                 ahb_htrans,
  input  logic [2:0]                 ahb_hburst,
  input  logic                       ahb_hready,
  input  logic [1:0]                 ahb_hresp,
  output logic [NUM_MST-1:0]         arb_hgrant,
  output logic [$clog2(NUM_MST)-1:0] arb_hmaster,
  output logic                       arb_hmastlock
);

  localparam int unsigned        PW      = $clog2(NUM_MST);
  localparam logic [NUM_MST-1:0] DEF_GNT = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;
  localparam logic [PW-1:0]      DEF_IDX = PW'(DEF_MST);

  htrans_e            trans;
  hburst_e            burst;
  hresp_e             resp;
  arb_state_e         state_q, state_d;
  logic [NUM_MST-1:0] grant_q, grant_d, pick_gnt;
  logic [PW-1:0]      gidx_q, gidx_d, pick_idx, pick_ptr;
  logic [4:0]         cnt_q, cnt_d;
  logic               rel_q, rel_d;
  logic               pick_valid, win, rearb, burst_end, abort;

  assign trans = htrans_e'(ahb_htrans);
  assign burst = hburst_e'(ahb_hburst);
  assign resp  = hresp_e'(ahb_hresp);

  ahb_arb_rr_pick #(
    .NUM_MST (NUM_MST),
    .PW      (PW)
  ) u_pick (
    .req   (mst_hbusreq),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef AHB_ARB_FIXED_PRIO_EN
  // Search start of 0 turns the picker into a lowest-index priority encoder.
  assign pick_ptr = PW'(NUM_MST - 1);
`else
  logic [PW-1:0] ptr_q;

  always_ff @(posedge clk or negedge ahb_hreset_n) begin
    if (!ahb_hreset_n)
      ptr_q <= DEF_IDX;
    else if (win)
      ptr_q <= pick_idx;
  end

  assign pick_ptr = ptr_q;
`endif

  // Beat tracking: counter reaching 1 on an accepted SEQ marks the last beat.
  always_comb begin
    abort     = (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
    burst_end = (trans == HTRANS_SEQ) && (cnt_q == 5'd2);
    cnt_d     = cnt_q;
    if (abort)
      cnt_d = '0;
    else if (trans == HTRANS_NONSEQ)
      cnt_d = burst_beats(burst);
    else if ((trans == HTRANS_SEQ) && (cnt_q > 5'd1))
      cnt_d = cnt_q - 5'd1;

    rearb = ahb_hready &&
            ((trans == HTRANS_IDLE) ||
             ((trans == HTRANS_NONSEQ) && ((burst == HBURST_SINGLE) || (burst == HBURST_INCR))) ||
             burst_end || abort);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rel_d   = rel_q;
    win     = 1'b0;
    if (rearb) begin
      if (mst_hlock[gidx_q]) begin
        state_d = ARB_LOCKED;
        rel_d   = 1'b0;
      end else if ((state_q == ARB_LOCKED) && !rel_q) begin
        // Lock just dropped: hold the bus for one more completed transfer.
        rel_d = 1'b1;
      end else begin
        rel_d = 1'b0;
        if (pick_valid) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = ARB_BUSY;
          win     = 1'b1;
        end else begin
          grant_d = DEF_GNT;
          gidx_d  = DEF_IDX;
          state_d = ARB_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge ahb_hreset_n) begin
    if (!ahb_hreset_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= DEF_GNT;
      gidx_q        <= DEF_IDX;
      cnt_q         <= '0;
      rel_q         <= 1'b0;
      arb_hmaster   <= DEF_IDX;
      arb_hmastlock <= 1'b0;
    end else if (ahb_hready) begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      cnt_q         <= cnt_d;
      rel_q         <= rel_d;
      arb_hmaster   <= gidx_q;
      arb_hmastlock <= mst_hlock[gidx_q];
    end
  end

  assign arb_hgrant = grant_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: behavioural model checked every cycle plus directed scenarios.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;
`ifdef AHB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [1:0]   tr = 2'd0;
  logic [2:0]   bu = 3'd0;
  logic         rdy = 1'b1;
  logic [1:0]   rsp = 2'd0;
  logic [N-1:0] arb_hgrant;
  logic [1:0]   arb_hmaster;
  logic         arb_hmastlock;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(
    .NUM_MST (N),
    .DEF_MST (DEF)
  ) dut (
    .clk           (clk),
    .ahb_hreset_n  (rst_n),
    .mst_hbusreq   (req),
    .mst_hlock     (lock),
    .ahb_htrans    (tr),
    .ahb_hburst    (bu),
    .ahb_hready    (rdy),
    .ahb_hresp     (rsp),
    .arb_hgrant    (arb_hgrant),
    .arb_hmaster   (arb_hmaster),
    .arb_hmastlock (arb_hmastlock)
  );

  // Model state: granted master, address-phase owner, beats still owed in a fixed burst.
  int m_gnt  = DEF;
  int m_own  = DEF;
  int m_last = DEF;
  int m_left = 0;
  bit m_mlock = 1'b0;
  bit m_locked = 1'b0;
  bit m_rel = 1'b0;

  function automatic int blen(input logic [2:0] b);
    return (b < 3'd2) ? 0 : (4 << ((int'(b) - 2) / 2));
  endfunction

  function automatic bit is_point(input logic [1:0] t, input logic [2:0] b,
                                  input logic [1:0] s, input int left);
    return (t == 2'd0) || (t == 2'd2 && b < 3'd2) || (s >= 2'd2) || (t == 2'd3 && left == 1);
  endfunction

  function automatic int pick(input logic [N-1:0] rq, input int last);
    int c;
    for (int k = 0; k < N; k++) begin
      c = FIXED ? k : (last + 1 + k) % N;
      if (rq[c[1:0]]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gnt <= DEF; m_own <= DEF; m_last <= DEF; m_left <= 0;
      m_mlock <= 1'b0; m_locked <= 1'b0; m_rel <= 1'b0;
    end else if (rdy) begin
      if (rsp >= 2'd2) m_left <= 0;
      else if (tr == 2'd2) m_left <= (blen(bu) > 0) ? blen(bu) - 1 : 0;
      else if (tr == 2'd3 && m_left > 0) m_left <= m_left - 1;
      m_own   <= m_gnt;
      m_mlock <= lock[m_gnt[1:0]];
      if (is_point(tr, bu, rsp, m_left)) begin
        if (lock[m_gnt[1:0]]) begin
          m_locked <= 1'b1; m_rel <= 1'b0;
        end else if (m_locked && !m_rel) begin
          m_rel <= 1'b1;
        end else begin
          m_locked <= 1'b0; m_rel <= 1'b0;
          if (pick(req, m_last) < 0) m_gnt <= DEF;
          else begin
            m_gnt  <= pick(req, m_last);
            m_last <= pick(req, m_last);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pin(input string nm, input int exp);
    chk(nm, 32'(arb_hgrant), 32'(exp));
    chk({nm, "_model"}, 32'(1) << m_gnt, 32'(exp));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_hgrant", 32'(arb_hgrant), 32'(1) << m_gnt);
      chk("cyc_hmaster", 32'(arb_hmaster), 32'(m_own));
      chk("cyc_hmastlock", 32'(arb_hmastlock), 32'(m_mlock));
    end
  end

  task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lk, input logic [1:0] t,
                     input logic [2:0] b, input logic r, input logic [1:0] s);
    req = rq; lock = lk; tr = t; bu = b; rdy = r; rsp = s;
    @(posedge clk);
    #2;
  endtask

  // INCR8 beats: NONSEQ, SEQ, BUSY, wait, SEQ, SEQ(ERROR), BUSY, SEQ, wait, SEQ, SEQ, last SEQ
  int bt [12] = '{2, 3, 1, 3, 3, 3, 1, 3, 3, 3, 3, 3};
  int br [12] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1};

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_hgrant", 32'(arb_hgrant), 32'h1);
    chk("rst_hmaster", 32'(arb_hmaster), 32'h0);
    chk("rst_hmastlock", 32'(arb_hmastlock), 32'h0);
    cyc(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    cyc(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    pin("park_idle", 1);

    for (int i = 0; i < 4; i++) begin
      cyc(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
      pin("rr_alt", (FIXED || i % 2 == 0) ? 2 : 4);
    end
    chk("rr_hmaster", 32'(arb_hmaster), 32'd1);

    cyc(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    cyc(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    chk("burst_owner", 32'(arb_hmaster), 32'd3);
    for (int i = 0; i < 12; i++) begin
      cyc((i < 5) ? 4'b1001 : 4'b0001, 4'b0000, 2'(bt[i]), 3'd5, 1'(br[i]),
          (i == 5) ? 2'd1 : 2'd0);
      pin("burst_hold", (i < 11) ? 8 : 1);
    end
    chk("burst_end_hmaster", 32'(arb_hmaster), 32'd3);
    cyc(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    chk("burst_next_hmaster", 32'(arb_hmaster), 32'd0);

    cyc(4'b0100, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    pin("lock_gnt", 4);
    cyc(4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 2'd0);
    chk("lock_mastlock", 32'(arb_hmastlock), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0110, 4'b0100, 2'd2, 3'd0, 1'b1, 2'd0);
      pin("lock_hold", 4);
      chk("lock_mastlock_hold", 32'(arb_hmastlock), 32'd1);
    end
    cyc(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    pin("lock_release_hold", 4);
    chk("lock_mastlock_drop", 32'(arb_hmastlock), 32'd0);
    cyc(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
    pin("lock_after", 2);

    cyc(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    pin("split_setup", 2);
    cyc(4'b1011, 4'b0000, 2'd2, 3'd3, 1'b1, 2'd0);
    pin("split_beat1", 2);
    cyc(4'b1011, 4'b0000, 2'd3, 3'd3, 1'b0, 2'd3);
    pin("split_wait", 2);
    cyc(4'b1011, 4'b0000, 2'd3, 3'd3, 1'b1, 2'd3);
    pin("split_rearb", FIXED ? 1 : 8);
    cyc(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    cyc(4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    chk("inc16_owner", 32'(arb_hmaster), 32'd3);

    cyc(4'b1001, 4'b0000, 2'd2, 3'd7, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1001, 4'b0000, 2'd3, 3'd7, 1'b1, 2'd0);
      pin("inc16_hold", 8);
    end
    req = 4'b1001; lock = 4'b0000; tr = 2'd3; bu = 3'd7; rdy = 1'b1; rsp = 2'd0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_hgrant", 32'(arb_hgrant), 32'h1);
    chk("async_hmaster", 32'(arb_hmaster), 32'h0);
    chk("async_hmastlock", 32'(arb_hmastlock), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(4'b1001, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    pin("post_reset_ptr", FIXED ? 1 : 8);
    cyc(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    pin("park_default", 1);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
